// File: rtl/rr_arbiter_16.sv
// rtl/rr_arbiter_16.sv - registered 16-way round-robin arbiter with one-hot grant and valid/ready hold
module rr_arbiter_16 #(
  parameter int N  = 16,
  parameter int PW = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         grant_ready,
  output logic         grant_valid,
  output logic [N-1:0] grant_onehot,
  output logic         grant_busy
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [N-1:0]    r_grant;
  logic [N-1:0]    w_grant_nxt;
  logic [PW-1:0]   r_ptr;
  logic [PW-1:0]   w_ptr_nxt;

  logic [PW-1:0]   w_win_idx;
  logic [PW-1:0]   w_acc_ptr;
  logic            w_accept;
  logic [PW-1:0]   w_search_ptr;
  logic [N-1:0]    w_rot;
  logic [N-1:0]    w_sel;
  logic [N-1:0]    w_win;

  // Index of the currently held grant; r_grant is one-hot or zero so OR-ing indices is exact.
  always_comb begin
    w_win_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (r_grant[i]) begin
        w_win_idx = w_win_idx | PW'(i);
      end
    end
  end

  // On accept the search restarts just past the winner, so a back-to-back grant uses the new pointer.
  assign w_accept     = (r_state == S_GRANT) && grant_ready;
  assign w_acc_ptr    = w_win_idx + PW'(1);
  assign w_search_ptr = w_accept ? w_acc_ptr : r_ptr;

  // Rotate requests so the search pointer lands at bit 0; pointer arithmetic wraps mod N on PW bits.
  always_comb begin
    w_rot = '0;
    for (int i = 0; i < N; i++) begin
      logic [PW-1:0] idx;
      idx      = PW'(i) + w_search_ptr;
      w_rot[i] = req[idx];
    end
  end

  // Isolate the lowest set bit of the rotated vector: a single winner by construction.
  assign w_sel = w_rot & (~w_rot + N'(1));

  // Rotate the selected bit back into requester numbering.
  always_comb begin
    w_win = '0;
    for (int i = 0; i < N; i++) begin
      logic [PW-1:0] idx;
      idx        = PW'(i) + w_search_ptr;
      w_win[idx] = w_sel[i];
    end
  end

  // Next-state, next-grant and pointer update; a held grant ignores req until accepted.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      S_IDLE: begin
        if (|req) begin
          w_grant_nxt = w_win;
          w_state_nxt = S_GRANT;
        end else begin
          w_grant_nxt = '0;
        end
      end
      S_GRANT: begin
        if (grant_ready) begin
          w_ptr_nxt = w_acc_ptr;
          if (|req) begin
            w_grant_nxt = w_win;
          end else begin
            w_grant_nxt = '0;
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  // State, grant and pointer registers; reset drops any pending grant at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  assign grant_valid  = (r_state == S_GRANT);
  assign grant_onehot = r_grant;
  assign grant_busy   = grant_valid && !grant_ready;

endmodule

// File: tb/tb_rr_arbiter_16.sv
// tb/tb_rr_arbiter_16.sv - directed and model-checked bench for rr_arbiter_16
module tb_rr_arbiter_16;

  logic        clk;
  logic        rst;
  logic [15:0] req;
  logic        grant_ready;
  logic        grant_valid;
  logic [15:0] grant_onehot;
  logic        grant_busy;

  int n_cmp;
  int n_err;

  rr_arbiter_16 dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .grant_ready  (grant_ready),
    .grant_valid  (grant_valid),
    .grant_onehot (grant_onehot),
    .grant_busy   (grant_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    tick();
    rst = 1'b0;
  endtask

  // reference model state for the random phase
  logic        m_valid;
  logic [15:0] m_grant;
  logic [3:0]  m_ptr;

  function automatic logic [15:0] m_search(input logic [15:0] r, input logic [3:0] p);
    logic [15:0] g;
    int          idx;
    g = '0;
    for (int k = 0; k < 16; k++) begin
      idx = (int'(p) + k) % 16;
      if (r[idx] && g == 16'h0) g[idx] = 1'b1;
    end
    return g;
  endfunction

  function automatic logic [3:0] m_index(input logic [15:0] g);
    logic [3:0] ix;
    ix = '0;
    for (int k = 0; k < 16; k++) if (g[k]) ix = 4'(k);
    return ix;
  endfunction

  initial begin
    logic [15:0] exp_g;
    logic [15:0] prev_g;
    logic        prev_stall;

    n_cmp       = 0;
    n_err       = 0;
    rst         = 1'b1;
    req         = 16'h0;
    grant_ready = 1'b0;
    #2;
    check("rst_valid", {31'd0, grant_valid}, 32'd0);
    check("rst_grant", {16'd0, grant_onehot}, 32'd0);
    check("rst_busy", {31'd0, grant_busy}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    tick();
    check("idle_no_req", {31'd0, grant_valid}, 32'd0);

    // basic grant, one cycle latency, then accept with req gone
    req = 16'h0010;
    tick();
    check("basic_grant", {16'd0, grant_onehot}, 32'h0010);
    check("basic_valid", {31'd0, grant_valid}, 32'd1);
    check("basic_busy", {31'd0, grant_busy}, 32'd1);
    req = 16'h0000;
    grant_ready = 1'b1;
    tick();
    check("basic_to_idle", {31'd0, grant_valid}, 32'd0);
    check("basic_idle_grant", {16'd0, grant_onehot}, 32'd0);
    // pointer now 5: all requesting should pick requester 5
    grant_ready = 1'b0;
    req = 16'hFFFF;
    tick();
    check("ptr_after_accept", {16'd0, grant_onehot}, 32'h0020);

    // asynchronous reset mid-grant
    rst = 1'b1;
    #1;
    check("midrst_valid", {31'd0, grant_valid}, 32'd0);
    check("midrst_grant", {16'd0, grant_onehot}, 32'd0);
    tick();
    rst = 1'b0;
    req = 16'h0000;
    tick();
    check("post_rst_idle", {31'd0, grant_valid}, 32'd0);

    // rotation through all 16 with wrap
    req = 16'hFFFF;
    grant_ready = 1'b1;
    for (int k = 0; k < 17; k++) begin
      tick();
      exp_g = 16'h1 << (k % 16);
      check($sformatf("rot_%0d", k), {16'd0, grant_onehot}, {16'd0, exp_g});
    end
    req = 16'h0000;
    tick();
    check("rot_idle", {31'd0, grant_valid}, 32'd0);

    // stall: grant held while req changes
    grant_ready = 1'b0;
    req = 16'h0100;
    tick();
    check("stall_first", {16'd0, grant_onehot}, 32'h0100);
    req = 16'h0001;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("stall_hold_%0d", k), {16'd0, grant_onehot}, 32'h0100);
      check($sformatf("stall_busy_%0d", k), {31'd0, grant_busy}, 32'd1);
    end
    grant_ready = 1'b1;
    #1;
    check("stall_busy_drop", {31'd0, grant_busy}, 32'd0);
    tick();
    check("stall_next", {16'd0, grant_onehot}, 32'h0001);
    // single requester granted every cycle
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("single_%0d", k), {16'd0, grant_onehot}, 32'h0001);
      check($sformatf("single_v_%0d", k), {31'd0, grant_valid}, 32'd1);
    end

    // fairness between 0 and 15 with pointer wrap
    do_reset();
    req = 16'h8001;
    grant_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      exp_g = (k % 2 == 0) ? 16'h0001 : 16'h8000;
      check($sformatf("fair_%0d", k), {16'd0, grant_onehot}, {16'd0, exp_g});
    end

    // random traffic against a loop-search reference model
    req = 16'h0;
    grant_ready = 1'b0;
    do_reset();
    m_valid = 1'b0;
    m_grant = '0;
    m_ptr = '0;
    prev_g = '0;
    prev_stall = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      req = 16'($urandom) & 16'($urandom);
      if ($urandom_range(0, 7) == 0) req = 16'h0;
      grant_ready = ($urandom_range(0, 2) != 0);
      if (!m_valid) begin
        m_grant = m_search(req, m_ptr);
        m_valid = (req != 16'h0);
      end else if (grant_ready) begin
        m_ptr = m_index(m_grant) + 4'd1;
        m_grant = m_search(req, m_ptr);
        m_valid = (req != 16'h0);
      end
      prev_stall = grant_valid && !grant_ready;
      prev_g = grant_onehot;
      tick();
      check("rnd_grant", {16'd0, grant_onehot}, {16'd0, m_grant});
      check("rnd_valid", {31'd0, grant_valid}, {31'd0, m_valid});
      check("rnd_onehot0", {31'd0, $onehot0(grant_onehot)}, 32'd1);
      check("rnd_nz_iff_valid", {31'd0, (grant_onehot != 16'h0)}, {31'd0, grant_valid});
      if (prev_stall) check("rnd_stall_stable", {16'd0, grant_onehot}, {16'd0, prev_g});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_16.md
# rr_arbiter_16

Registered round-robin arbiter that turns 16 independent request lines into a single one-hot grant vector. It sits directly upstream of the 16-to-4 encoder, which converts the grant into a 4-bit index. The output grant is always either all-zero or exactly one-hot, so the encoder never sees an illegal multi-hot code. A valid/ready handshake holds each grant stable until the downstream consumer accepts it. A rotating priority pointer provides starvation-free fairness.

## Interface

Parameters:
- N, 16, number of requesters. The design targets 16; the grant width equals N.
- PW, 4, pointer width, equal to clog2(N).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous and active-high.
- req  input  N  request lines; bit i high means requester i wants service. Level-sensitive and sampled every cycle.
- grant_ready  input  1  downstream (encoder consumer) accepts the current grant.
- grant_valid  output  1  grant_onehot holds a live grant.
- grant_onehot  output  N  registered grant; exactly one bit set when grant_valid=1, all zero otherwise.
- grant_busy  output  1  high when grant_valid=1 and grant_ready=0 (stall indicator). Combinational from registered state and grant_ready.

## Operation

- **State machine** (2 states):
  - IDLE: grant_valid=0.
  - GRANT: grant_valid=1, grant_onehot holds the winner.
- **Priority pointer** ptr (PW bits): the search starts at index ptr and proceeds upward through ptr+1, …, N-1, then wraps to 0, …, ptr-1. The first set req bit wins.
- **IDLE**: if req != 0, register the winner into grant_onehot and move to GRANT. If req == 0, stay in IDLE with grant_onehot = 0.
- **GRANT, grant_ready=0**: hold grant_onehot and ptr unchanged. Changes on req are ignored, including deassertion of the granted bit; grants are never retracted.
- **GRANT, grant_ready=1 (accept)**:
  - Set ptr to (winner index + 1) mod N. Index 15 wraps to 0.
  - In the same cycle, re-arbitrate on the current req using the updated pointer.
  - If any req bit is set, load the new winner and stay in GRANT (back-to-back grant). Otherwise clear grant_onehot and go to IDLE.
- **Fairness**: a continuously asserted requester is granted within N accepted grants.
- The winner search is an N-wide rotate, priority-select, and rotate-back. No multi-hot result is possible; the arithmetic is mod N on PW bits.

## Timing

- **Reset values** (asynchronous): grant_valid=0, grant_onehot=0, grant_busy=0, ptr=0, state=IDLE.
- **Reset mid-operation**: a pending grant is dropped immediately, with no accept event.
- **Latency**: req rising in IDLE at cycle t produces grant_valid=1 at cycle t+1.
- **Throughput**: with grant_ready held at 1 and requests pending, there is one new grant per cycle with no bubble.
- **Handshake**: a grant is transferred on a clock edge where grant_valid=1 and grant_ready=1. grant_onehot must not change while grant_valid=1 and grant_ready=0.
- **grant_ready while grant_valid=0**: ignored; it does not affect ptr.
- **Pointer wrap**: winner 15 gives ptr=0.
- **Single requester**: the same requester is granted every accept, with no gaps.
- **All 16 requesting, grant_ready=1**: grants rotate 0,1,…,15,0,… on consecutive cycles.

## Test plan

- **Reset**: assert rst mid-grant -> grant_valid=0, grant_onehot=16'h0000 immediately. After release with req=16'h0000 -> stays IDLE.
- **Basic grant**: req=16'h0010 at cycle t with ptr=0 -> grant_onehot=16'h0010, grant_valid=1 at t+1. Accept -> ptr=5, then IDLE once req=0.
- **Rotation**: req=16'hFFFF held, grant_ready=1 -> grant_onehot steps 0001, 0002, …, 8000, 0001 on consecutive cycles (wrap check).
- **Stall**: grant held with grant_ready=0 for 5 cycles while req changes from 16'h0100 to 16'h0001 -> grant_onehot stays 16'h0100 and grant_busy=1 throughout. Then accept -> next grant 16'h0001.
- **Fairness**: req=16'h8001, ptr=0, always ready -> grants alternate 16'h0001, 16'h8000, 16'h0001, …
- **One-hot invariant**: random req and grant_ready for 10k cycles -> grant_onehot is always 0 or one-hot. It is nonzero iff grant_valid=1, and it is stable under stall.
